// File: rtl/sdram_filter_pkg.sv
// rtl/sdram_filter_pkg.sv - shared types and the channel saturate/add helper for the SDRAM row filter engine
package sdram_filter_pkg;

    typedef enum logic [1:0] {
        FM_PASS   = 2'b00,
        FM_BRIGHT = 2'b01,
        FM_BLUR   = 2'b10,
        FM_INVERT = 2'b11
    } filter_mode_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD_REQ,
        ST_RD_WAIT,
        ST_COMPUTE,
        ST_WR_REQ,
        ST_ADVANCE,
        ST_DONE
    } state_e;

    // Unsigned channel (zero-extended to 32 bits) plus sign-extended 8-bit offset,
    // clamped to [0, 2^cw-1]. Callers size-cast the result to their channel width.
    function automatic logic [31:0] sat_add_beta(input logic [31:0] c,
                                                 input logic [7:0]  beta,
                                                 input int unsigned cw);
        logic signed [33:0] s_sum;
        logic signed [33:0] s_max;
        s_sum = $signed({2'b00, c}) + $signed({{26{beta[7]}}, beta});
        s_max = $signed((34'd1 << cw) - 34'd1);
        if (s_sum < 34'sd0) begin
            return 32'd0;
        end else if (s_sum > s_max) begin
            return s_max[31:0];
        end else begin
            return s_sum[31:0];
        end
    endfunction

endpackage

// File: rtl/filter_channel_alu.sv
// rtl/filter_channel_alu.sv - one channel: blur history, accumulator, filter mode mux, registered result
//  clk, n_rst  : clock, async active-low reset
//  i_en        : advance history and register a new result (COMPUTE cycle)
//  i_edge      : first column of a row; history is replaced by the current sample
//  i_mode      : filter select
//  i_beta      : signed brightness offset
//  i_pixel     : current channel sample
//  o_result    : filtered channel, valid from the cycle after i_en
module filter_channel_alu
    import sdram_filter_pkg::*;
#(
    parameter int CHANNEL_WIDTH = 8,
    parameter int LOG2_TAPS     = 2,    // must be >= 1
    parameter bit BYPASS        = 1'b0  // copy input unfiltered (alpha channel)
) (
    input  logic                     clk,
    input  logic                     n_rst,
    input  logic                     i_en,
    input  logic                     i_edge,
    input  filter_mode_e             i_mode,
    input  logic [7:0]               i_beta,
    input  logic [CHANNEL_WIDTH-1:0] i_pixel,
    output logic [CHANNEL_WIDTH-1:0] o_result
);
    localparam int TAPS  = 1 << LOG2_TAPS;
    localparam int HIST  = TAPS - 1;
    localparam int ACC_W = CHANNEL_WIDTH + LOG2_TAPS;

    // Only the T-1 previous samples are stored; the current sample completes the window.
    logic [CHANNEL_WIDTH-1:0] r_hist [HIST];
    logic [ACC_W-1:0]         w_acc;
    logic [CHANNEL_WIDTH-1:0] w_result;

    always_comb begin
        w_acc = ACC_W'(i_pixel);
        for (int k = 0; k < HIST; k++) begin
            w_acc = w_acc + ACC_W'(i_edge ? i_pixel : r_hist[k]);
        end
    end

    always_comb begin
        w_result = i_pixel;
        if (!BYPASS) begin
            unique case (i_mode)
                FM_PASS:   w_result = i_pixel;
                FM_BRIGHT: w_result = CHANNEL_WIDTH'(sat_add_beta(32'(i_pixel), i_beta, CHANNEL_WIDTH));
                FM_BLUR:   w_result = CHANNEL_WIDTH'(w_acc >> LOG2_TAPS);
                FM_INVERT: w_result = ~i_pixel;
                default:   w_result = i_pixel;
            endcase
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            for (int k = 0; k < HIST; k++) begin
                r_hist[k] <= '0;
            end
            o_result <= '0;
        end else if (i_en) begin
            r_hist[0] <= i_pixel;
            for (int k = 1; k < HIST; k++) begin
                r_hist[k] <= i_edge ? i_pixel : r_hist[k-1];
            end
            o_result <= w_result;
        end
    end

endmodule

// File: rtl/sdram_row_filter_engine.sv
// rtl/sdram_row_filter_engine.sv - streams pixels src->filter->dst through SDRAM, one read then one write per pixel
//  clk, n_rst                      : clock, async active-low reset
//  startControlRegister            : level start, sampled in IDLE; drop to leave DONE
//  imageWidth/imageHeight          : last column / last row index
//  start_addr_sdram/finish_addr_sdram : source / destination base word address
//  filterMode, betaValue           : filter select, signed brightness offset
//  data_sdram, sdram_datareadvalid : read data and its strobe
//  sdram_waitrequest               : holds the current request
//  sdram_read_en/sdram_write_en    : requests; address_sdram, writeData_sdram
//  finish_flag                     : image complete
module sdram_row_filter_engine
    import sdram_filter_pkg::*;
#(
    parameter int ADDR_WIDTH    = 26,
    parameter int DIM_WIDTH     = 13,
    parameter int NUM_CHANNELS  = 4,
    parameter int CHANNEL_WIDTH = 8,
    parameter int LOG2_TAPS     = 2,
    parameter int PASS_ALPHA    = 1
) (
    input  logic                                    clk,
    input  logic                                    n_rst,
    input  logic                                    startControlRegister,
    input  logic [DIM_WIDTH-1:0]                    imageWidth,
    input  logic [DIM_WIDTH-1:0]                    imageHeight,
    input  logic [ADDR_WIDTH-1:0]                   start_addr_sdram,
    input  logic [ADDR_WIDTH-1:0]                   finish_addr_sdram,
    input  logic [1:0]                              filterMode,
    input  logic [7:0]                              betaValue,
    input  logic [NUM_CHANNELS*CHANNEL_WIDTH-1:0]   data_sdram,
    input  logic                                    sdram_datareadvalid,
    input  logic                                    sdram_waitrequest,
    output logic                                    sdram_read_en,
    output logic                                    sdram_write_en,
    output logic [ADDR_WIDTH-1:0]                   address_sdram,
    output logic [NUM_CHANNELS*CHANNEL_WIDTH-1:0]   writeData_sdram,
    output logic                                    finish_flag
);
    localparam int PW = NUM_CHANNELS * CHANNEL_WIDTH;

    state_e                  r_state;
    state_e                  w_state_next;
    logic [ADDR_WIDTH-1:0]   r_src;
    logic [ADDR_WIDTH-1:0]   r_dst;
    logic [ADDR_WIDTH-1:0]   r_p;
    logic [DIM_WIDTH-1:0]    r_width;
    logic [DIM_WIDTH-1:0]    r_height;
    logic [DIM_WIDTH-1:0]    r_col;
    logic [DIM_WIDTH-1:0]    r_row;
    filter_mode_e            r_mode;
    logic [7:0]              r_beta;
    logic [PW-1:0]           r_pix;
    logic                    w_latch;
    logic                    w_capture;
    logic                    w_compute;
    logic                    w_advance;
    logic                    w_last;
    logic [CHANNEL_WIDTH-1:0] w_res [NUM_CHANNELS];

    assign w_last = (r_col == r_width) && (r_row == r_height);

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Requests and address are decoded from state so a reset drops them in the same cycle.
    always_comb begin
        w_state_next   = r_state;
        sdram_read_en  = 1'b0;
        sdram_write_en = 1'b0;
        address_sdram  = '0;
        finish_flag    = 1'b0;
        w_latch        = 1'b0;
        w_capture      = 1'b0;
        w_compute      = 1'b0;
        w_advance      = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (startControlRegister) begin
                    w_latch      = 1'b1;
                    w_state_next = ST_RD_REQ;
                end
            end
            ST_RD_REQ: begin
                sdram_read_en = 1'b1;
                address_sdram = r_src + r_p;
                if (!sdram_waitrequest) w_state_next = ST_RD_WAIT;
            end
            ST_RD_WAIT: begin
                address_sdram = r_src + r_p;
                if (sdram_datareadvalid) begin
                    w_capture    = 1'b1;
                    w_state_next = ST_COMPUTE;
                end
            end
            ST_COMPUTE: begin
                w_compute    = 1'b1;
                w_state_next = ST_WR_REQ;
            end
            ST_WR_REQ: begin
                sdram_write_en = 1'b1;
                address_sdram  = r_dst + r_p;
                if (!sdram_waitrequest) w_state_next = ST_ADVANCE;
            end
            ST_ADVANCE: begin
                w_advance    = 1'b1;
                w_state_next = w_last ? ST_DONE : ST_RD_REQ;
            end
            ST_DONE: begin
                finish_flag = 1'b1;
                if (!startControlRegister) w_state_next = ST_IDLE;
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_src    <= '0;
            r_dst    <= '0;
            r_p      <= '0;
            r_width  <= '0;
            r_height <= '0;
            r_col    <= '0;
            r_row    <= '0;
            r_mode   <= FM_PASS;
            r_beta   <= '0;
            r_pix    <= '0;
        end else begin
            if (w_latch) begin
                r_src    <= start_addr_sdram;
                r_dst    <= finish_addr_sdram;
                r_width  <= imageWidth;
                r_height <= imageHeight;
                r_mode   <= filter_mode_e'(filterMode);
                r_beta   <= betaValue;
                r_p      <= '0;
                r_col    <= '0;
                r_row    <= '0;
            end
            if (w_capture) begin
                r_pix <= data_sdram;
            end
            if (w_advance) begin
                r_p <= r_p + ADDR_WIDTH'(1);
                if (r_col == r_width) begin
                    r_col <= '0;
                    r_row <= r_row + DIM_WIDTH'(1);
                end else begin
                    r_col <= r_col + DIM_WIDTH'(1);
                end
            end
        end
    end

    for (genvar c = 0; c < NUM_CHANNELS; c++) begin : g_ch
        filter_channel_alu #(
            .CHANNEL_WIDTH (CHANNEL_WIDTH),
            .LOG2_TAPS     (LOG2_TAPS),
            .BYPASS        ((PASS_ALPHA != 0) && (c == NUM_CHANNELS - 1))
        ) u_alu (
            .clk      (clk),
            .n_rst    (n_rst),
            .i_en     (w_compute),
            .i_edge   (r_col == '0),
            .i_mode   (r_mode),
            .i_beta   (r_beta),
            .i_pixel  (r_pix[c*CHANNEL_WIDTH +: CHANNEL_WIDTH]),
            .o_result (w_res[c])
        );
    end

    always_comb begin
        writeData_sdram = '0;
        for (int c = 0; c < NUM_CHANNELS; c++) begin
            writeData_sdram[c*CHANNEL_WIDTH +: CHANNEL_WIDTH] = w_res[c];
        end
    end

endmodule

// File: tb/tb_sdram_row_filter_engine.sv
// tb/tb_sdram_row_filter_engine.sv - directed self-checking bench with a stalling SDRAM model
module tb_sdram_row_filter_engine;

    logic        clk = 1'b0;
    logic        n_rst;
    logic        startControlRegister;
    logic [12:0] imageWidth;
    logic [12:0] imageHeight;
    logic [25:0] start_addr_sdram;
    logic [25:0] finish_addr_sdram;
    logic [1:0]  filterMode;
    logic [7:0]  betaValue;
    logic [31:0] data_sdram;
    logic        sdram_datareadvalid;
    logic        sdram_waitrequest;
    logic        sdram_read_en;
    logic        sdram_write_en;
    logic [25:0] address_sdram;
    logic [31:0] writeData_sdram;
    logic        finish_flag;

    sdram_row_filter_engine dut (
        .clk                  (clk),
        .n_rst                (n_rst),
        .startControlRegister (startControlRegister),
        .imageWidth           (imageWidth),
        .imageHeight          (imageHeight),
        .start_addr_sdram     (start_addr_sdram),
        .finish_addr_sdram    (finish_addr_sdram),
        .filterMode           (filterMode),
        .betaValue            (betaValue),
        .data_sdram           (data_sdram),
        .sdram_datareadvalid  (sdram_datareadvalid),
        .sdram_waitrequest    (sdram_waitrequest),
        .sdram_read_en        (sdram_read_en),
        .sdram_write_en       (sdram_write_en),
        .address_sdram        (address_sdram),
        .writeData_sdram      (writeData_sdram),
        .finish_flag          (finish_flag)
    );

    always #5 clk = ~clk;

    logic [31:0] mem [256];
    bit          was_read [256];
    int          n_checks = 0;
    int          n_fail = 0;
    int          reads, writes, addr_err, order_err, both_err;
    int          stall_cycles, read_delay, stall_left, delay_left;
    bit          spur_en, spur_pend, req_active, pending;
    logic [31:0] pend_data;
    logic [25:0] req_addr, cur_src, cur_dst;

    logic [31:0] blur_in  [8] = '{32'h5A04FF00, 32'h5A00FF40, 32'h5A00FF80, 32'h5A00FFC0,
                                  32'h11000140, 32'h11000200, 32'h11000300, 32'h11000400};
    logic [31:0] blur_exp [8] = '{32'h5A04FF00, 32'h5A03FF10, 32'h5A02FF30, 32'h5A01FF60,
                                  32'h11000140, 32'h11000130, 32'h11000120, 32'h11000210};

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ramp(input int i);
        return {8'(160 + i), 8'(48 + i), 8'(32 + i), 8'(16 + i)};
    endfunction

    // SDRAM model: all decisions at negedge, so DUT outputs are stable and inputs settle before posedge.
    initial begin
        sdram_waitrequest   = 1'b0;
        sdram_datareadvalid = 1'b0;
        data_sdram          = '0;
        forever begin
            @(negedge clk);
            sdram_datareadvalid = 1'b0;
            if (!n_rst) begin
                req_active = 0; pending = 0; spur_pend = 0; sdram_waitrequest = 1'b0;
            end else begin
                if (sdram_read_en && sdram_write_en) both_err++;
                if (spur_pend) begin
                    sdram_datareadvalid = 1'b1; data_sdram = 32'hDEADBEEF; spur_pend = 0;
                end
                if (pending) begin
                    if (delay_left == 0) begin
                        sdram_datareadvalid = 1'b1; data_sdram = pend_data; pending = 0;
                    end else begin
                        delay_left--;
                    end
                end
                if (sdram_read_en || sdram_write_en) begin
                    if (!req_active) begin
                        req_active = 1; stall_left = stall_cycles; req_addr = address_sdram;
                    end else if (address_sdram != req_addr) begin
                        addr_err++;
                    end
                    if (stall_left > 0) begin
                        sdram_waitrequest = 1'b1; stall_left--;
                    end else begin
                        sdram_waitrequest = 1'b0; req_active = 0;
                        if (sdram_read_en) begin
                            reads++;
                            was_read[8'(address_sdram - cur_src)] = 1;
                            pending = 1; delay_left = read_delay;
                            pend_data = mem[address_sdram[7:0]];
                        end else begin
                            writes++;
                            if (!was_read[8'(address_sdram - cur_dst)]) order_err++;
                            mem[address_sdram[7:0]] = writeData_sdram;
                            if (spur_en) spur_pend = 1;
                        end
                    end
                end else begin
                    sdram_waitrequest = 1'b0;
                end
            end
        end
    end

    task automatic start_image(input logic [25:0] src, input logic [25:0] dst,
                               input logic [12:0] w, input logic [12:0] h,
                               input logic [1:0] mode, input logic [7:0] beta,
                               input int stall, input int rdelay, input bit spur);
        cur_src = src; cur_dst = dst;
        stall_cycles = stall; read_delay = rdelay; spur_en = spur;
        reads = 0; writes = 0; addr_err = 0; order_err = 0;
        for (int i = 0; i < 256; i++) was_read[i] = 0;
        start_addr_sdram = src; finish_addr_sdram = dst;
        imageWidth = w; imageHeight = h; filterMode = mode; betaValue = beta;
        startControlRegister = 1'b1;
        @(negedge clk);
        @(negedge clk);
        // Config is latched by now; disturbing it must not affect the run.
        start_addr_sdram = 26'h00000F0; finish_addr_sdram = 26'h00000F8;
        imageWidth = 13'd1; imageHeight = 13'd0; filterMode = ~mode; betaValue = ~beta;
    endtask

    task automatic run_image(input string tag, input logic [25:0] src, input logic [25:0] dst,
                             input logic [12:0] w, input logic [12:0] h,
                             input logic [1:0] mode, input logic [7:0] beta,
                             input int stall, input int rdelay, input bit spur);
        int n;
        int cnt;
        n = (int'(w) + 1) * (int'(h) + 1);
        start_image(src, dst, w, h, mode, beta, stall, rdelay, spur);
        cnt = 0;
        while (!finish_flag && cnt < 5000) begin
            @(negedge clk);
            cnt++;
        end
        check_eq({tag, "_finish"}, 32'(finish_flag), 32'd1);
        check_eq({tag, "_reads"}, reads, n);
        check_eq({tag, "_writes"}, writes, n);
        check_eq({tag, "_order"}, order_err, 0);
        check_eq({tag, "_addr_stable"}, addr_err, 0);
        startControlRegister = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check_eq({tag, "_finish_clr"}, 32'(finish_flag), 32'd0);
    endtask

    task automatic check_idle_outputs(input string tag);
        check_eq({tag, "_rd"}, 32'(sdram_read_en), 32'd0);
        check_eq({tag, "_wr"}, 32'(sdram_write_en), 32'd0);
        check_eq({tag, "_addr"}, 32'(address_sdram), 32'd0);
        check_eq({tag, "_wdata"}, writeData_sdram, 32'd0);
        check_eq({tag, "_finish"}, 32'(finish_flag), 32'd0);
    endtask

    initial begin
        int k;
        int cnt;
        bit found;
        n_rst = 1'b0; startControlRegister = 1'b0;
        imageWidth = '0; imageHeight = '0; start_addr_sdram = '0; finish_addr_sdram = '0;
        filterMode = '0; betaValue = '0;
        for (int i = 0; i < 256; i++) mem[i] = '0;
        repeat (3) @(negedge clk);
        check_idle_outputs("reset");
        n_rst = 1'b1;
        @(negedge clk);

        // Pass-through 4x2 ramp
        for (int i = 0; i < 8; i++) mem[i] = ramp(i);
        run_image("t1", 26'h00, 26'h40, 13'd3, 13'd1, 2'b00, 8'h00, 0, 0, 0);
        for (int i = 0; i < 8; i++) check_eq($sformatf("t1_px%0d", i), mem[8'h40 + i], ramp(i));

        // Brightness +20 and -20 with clamping at both ends
        mem[8'h10] = 32'h7F0010F0; mem[8'h11] = 32'h8005EB14;
        run_image("t2p", 26'h10, 26'h50, 13'd1, 13'd0, 2'b01, 8'h14, 0, 0, 0);
        check_eq("t2p_px0", mem[8'h50], 32'h7F1424FF);
        check_eq("t2p_px1", mem[8'h51], 32'h8019FF28);
        mem[8'h12] = 32'h33051415; mem[8'h13] = 32'hFF00FF80;
        run_image("t2n", 26'h12, 26'h52, 13'd1, 13'd0, 2'b01, 8'hEC, 0, 0, 0);
        check_eq("t2n_px0", mem[8'h52], 32'h33000001);
        check_eq("t2n_px1", mem[8'h53], 32'hFF00EB6C);

        // Box blur T=4, second row restarts with edge replication
        for (int i = 0; i < 8; i++) mem[8'h20 + i] = blur_in[i];
        run_image("t3", 26'h20, 26'h60, 13'd3, 13'd1, 2'b10, 8'h00, 0, 0, 0);
        for (int i = 0; i < 8; i++) check_eq($sformatf("t3_px%0d", i), mem[8'h60 + i], blur_exp[i]);

        // Same blur under waitrequest stalls, slow read data and stray read strobes
        run_image("t4", 26'h20, 26'h68, 13'd3, 13'd1, 2'b10, 8'h00, 3, 5, 1);
        for (int i = 0; i < 8; i++) check_eq($sformatf("t4_px%0d", i), mem[8'h68 + i], blur_exp[i]);

        // In-place invert 3x3, then a single-pixel image
        for (int i = 0; i < 9; i++) mem[8'h80 + i] = {8'hA5, 8'(i * 16), 8'(i + 1), 8'(i * 3)};
        run_image("t5", 26'h80, 26'h80, 13'd2, 13'd2, 2'b11, 8'h00, 0, 0, 0);
        for (int i = 0; i < 9; i++)
            check_eq($sformatf("t5_px%0d", i), mem[8'h80 + i],
                     {8'hA5, 8'(255 - i * 16), 8'(254 - i), 8'(255 - i * 3)});
        mem[8'hA0] = 32'h12345678;
        run_image("t5s", 26'hA0, 26'hA0, 13'd0, 13'd0, 2'b11, 8'h00, 0, 0, 0);
        check_eq("t5s_px", mem[8'hA0], 32'h12CBA987);

        // Reset in the middle of a stalled write, then restart with a different config
        for (int i = 0; i < 8; i++) mem[8'hC0 + i] = 32'hDEADDEAD;
        start_image(26'h00, 26'hC0, 13'd3, 13'd1, 2'b00, 8'h00, 3, 0, 0);
        found = 0; cnt = 0;
        while (!found && cnt < 2000) begin
            @(negedge clk);
            #2;
            if (sdram_write_en && writes >= 2) found = 1;
            cnt++;
        end
        check_eq("t6_write_seen", 32'(found), 32'd1);
        k = writes;
        n_rst = 1'b0;
        #1;
        check_idle_outputs("t6_abort");
        check_eq("t6_no_partial", mem[8'(8'hC0 + k)], 32'hDEADDEAD);
        check_eq("t6_prev_done", mem[8'(8'hC0 + k - 1)], ramp(k - 1));
        startControlRegister = 1'b0;
        @(negedge clk);
        @(negedge clk);
        n_rst = 1'b1;
        @(negedge clk);
        run_image("t6r", 26'h00, 26'hC0, 13'd3, 13'd1, 2'b11, 8'h00, 0, 0, 0);
        for (int i = 0; i < 8; i++)
            check_eq($sformatf("t6r_px%0d", i), mem[8'hC0 + i], {ramp(i) >> 24, 24'hFFFFFF} ^ {8'h00, ramp(i) & 32'h00FFFFFF} & 32'hFFFFFFFF);

        check_eq("no_rd_wr_overlap", both_err, 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
